// File: rtl/mig7_memtest.sv
// Purpose: DDR3 bring-up traffic generator on the MIG7 app_* interface: writes an address-derived pattern, reads it back, compares.
// Latency: enters WRITE the cycle after start; done rises on the edge that accepts the last returned read beat (or on abort).
// Backpressure: commands wait on app_rdy and write beats on app_wdf_rdy, each independently; read beats are never stalled.
module mig7_memtest #(
    parameter logic [27:0] ADDR_BEGIN = 28'h0000000,
    parameter int unsigned CMD_COUNT  = 1024,
    parameter logic [31:0] SEED       = 32'hA5A5_5A5A,
    parameter int unsigned TIMEOUT    = 65536
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         init_calib_complete,
    output logic [27:0]  app_addr,
    output logic [2:0]   app_cmd,
    output logic         app_en,
    input  logic         app_rdy,
    output logic [127:0] app_wdf_data,
    output logic [15:0]  app_wdf_mask,
    output logic         app_wdf_wren,
    output logic         app_wdf_end,
    input  logic         app_wdf_rdy,
    input  logic [127:0] app_rd_data,
    input  logic         app_rd_data_valid,
    input  logic         app_rd_data_end,
    output logic         app_sr_req,
    output logic         app_ref_req,
    output logic         app_zq_req,
    input  logic         app_sr_active,
    input  logic         app_ref_ack,
    input  logic         app_zq_ack,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         timeout,
    output logic [31:0]  error_count,
    output logic [27:0]  first_err_addr
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_WRITE = 2'd1;
    localparam logic [1:0]  S_READ  = 2'd2;
    localparam logic [1:0]  S_DONE  = 2'd3;
    localparam logic [2:0]  CMD_WR  = 3'b000;
    localparam logic [2:0]  CMD_RD  = 3'b001;
    localparam logic [24:0] LAST_IDX  = 25'(CMD_COUNT - 1);
    localparam logic [24:0] ALL_CMDS  = 25'(CMD_COUNT);
    localparam logic [31:0] WD_LAST   = 32'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [24:0] cmd_idx;     // index of the command currently offered
    logic [24:0] ret_idx;     // index of the next read beat expected back
    logic [27:0] cmd_addr;
    logic [27:0] ret_addr;
    logic        cmd_ok;      // write command of this beat already accepted
    logic        dat_ok;      // write data of this beat already accepted
    logic [31:0] wd_cnt;

    logic cmd_acc, dat_acc, beat, activity, running;
    logic pair_done, mismatch, wd_fire, abort, finish, run_start;

    // Four copies of the address XOR seed; copy 0 sits in the low word.
    function automatic logic [127:0] pattern(input logic [27:0] a);
        logic [31:0] w;
        w = {4'h0, a} ^ SEED;
        return {4{w}};
    endfunction

    // Inputs the design deliberately does not use.
    logic unused_ok;
    assign unused_ok = ^{app_rd_data_end, app_sr_active, app_ref_ack, app_zq_ack};

    assign running      = (state == S_WRITE) || (state == S_READ);
    assign app_en       = ((state == S_WRITE) && !cmd_ok) || ((state == S_READ) && (cmd_idx != ALL_CMDS));
    assign app_wdf_wren = (state == S_WRITE) && !dat_ok;
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_mask = 16'h0000;
    assign app_cmd      = (state == S_READ) ? CMD_RD : CMD_WR;
    assign app_addr     = running ? cmd_addr : 28'h0;
    assign app_wdf_data = (state == S_WRITE) ? pattern(cmd_addr) : 128'h0;
    assign app_sr_req   = 1'b0;
    assign app_ref_req  = 1'b0;
    assign app_zq_req   = 1'b0;

    assign cmd_acc   = app_en & app_rdy;
    assign dat_acc   = app_wdf_wren & app_wdf_rdy;
    assign beat      = (state == S_READ) & app_rd_data_valid;
    assign activity  = cmd_acc | dat_acc | beat;
    assign pair_done = (cmd_ok | cmd_acc) & (dat_ok | dat_acc);
    assign mismatch  = beat & (app_rd_data != pattern(ret_addr));
    assign wd_fire   = !activity && (wd_cnt == WD_LAST);
    // Calibration loss is handled exactly like a watchdog expiry.
    assign abort     = running & (wd_fire | !init_calib_complete);
    assign finish    = beat & (ret_idx == LAST_IDX);
    assign run_start = start & init_calib_complete & ((state == S_IDLE) || (state == S_DONE));
    assign pass      = done & ~timeout & (error_count == 32'h0);

    // Sequencing: FSM, command/return counters, per-beat handshake flags and the watchdog.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cmd_idx  <= 25'd0;
            ret_idx  <= 25'd0;
            cmd_addr <= 28'h0;
            ret_addr <= 28'h0;
            cmd_ok   <= 1'b0;
            dat_ok   <= 1'b0;
            wd_cnt   <= 32'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (run_start) begin
                        state    <= S_WRITE;
                        cmd_idx  <= 25'd0;
                        cmd_addr <= ADDR_BEGIN;
                        cmd_ok   <= 1'b0;
                        dat_ok   <= 1'b0;
                        wd_cnt   <= 32'd0;
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        state <= S_DONE;
                    end else begin
                        wd_cnt <= activity ? 32'd0 : wd_cnt + 32'd1;
                        if (pair_done) begin
                            cmd_ok <= 1'b0;
                            dat_ok <= 1'b0;
                            if (cmd_idx == LAST_IDX) begin
                                state    <= S_READ;
                                cmd_idx  <= 25'd0;
                                cmd_addr <= ADDR_BEGIN;
                                ret_idx  <= 25'd0;
                                ret_addr <= ADDR_BEGIN;
                            end else begin
                                cmd_idx  <= cmd_idx + 25'd1;
                                cmd_addr <= cmd_addr + 28'd8;
                            end
                        end else begin
                            cmd_ok <= cmd_ok | cmd_acc;
                            dat_ok <= dat_ok | dat_acc;
                        end
                    end
                end
                S_READ: begin
                    if (abort) begin
                        state <= S_DONE;
                    end else begin
                        wd_cnt <= activity ? 32'd0 : wd_cnt + 32'd1;
                        if (cmd_acc) begin
                            cmd_idx  <= cmd_idx + 25'd1;
                            cmd_addr <= cmd_addr + 28'd8;
                        end
                        if (beat) begin
                            ret_idx  <= ret_idx + 25'd1;
                            ret_addr <= ret_addr + 28'd8;
                            if (finish) begin
                                state <= S_DONE;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status: busy/done/timeout flags plus the saturating error count and first failing address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            error_count    <= 32'h0;
            first_err_addr <= 28'h0;
        end else if (run_start) begin
            busy           <= 1'b1;
            done           <= 1'b0;
            timeout        <= 1'b0;
            error_count    <= 32'h0;
            first_err_addr <= 28'h0;
        end else if (running) begin
            if (mismatch) begin
                if (error_count == 32'h0) begin
                    first_err_addr <= ret_addr;
                end
                if (error_count != 32'hFFFF_FFFF) begin
                    error_count <= error_count + 32'd1;
                end
            end
            if (abort) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                timeout <= 1'b1;
            end else if (finish) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule
